// File: rtl/peripheral_mpram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : peripheral_mpram_arbiter
// Description : Round-robin arbiter of two memory-request ports onto one
//               byte-writable synchronous RAM array with registered responses.
// Revision    : 1.0 - initial release
// ============================================================================
module peripheral_mpram_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 256,
    localparam int BE_WIDTH  = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,

    input  logic                  req0_i,
    input  logic                  we0_i,
    input  logic [ADDR_WIDTH-1:0] addr0_i,
    input  logic [BE_WIDTH-1:0]   be0_i,
    input  logic [DATA_WIDTH-1:0] data0_i,
    output logic                  gnt0_o,
    output logic                  rvalid0_o,
    output logic [DATA_WIDTH-1:0] data0_o,

    input  logic                  req1_i,
    input  logic                  we1_i,
    input  logic [ADDR_WIDTH-1:0] addr1_i,
    input  logic [BE_WIDTH-1:0]   be1_i,
    input  logic [DATA_WIDTH-1:0] data1_i,
    output logic                  gnt1_o,
    output logic                  rvalid1_o,
    output logic [DATA_WIDTH-1:0] data1_o
);

    localparam int c_OFS  = (BE_WIDTH > 1) ? $clog2(BE_WIDTH) : 0;
    localparam int c_IDXW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  r_last;
    logic                  r_rvalid0;
    logic                  r_rvalid1;
    logic [DATA_WIDTH-1:0] r_data0;
    logic [DATA_WIDTH-1:0] r_data1;

    logic                  w_gnt0;
    logic                  w_gnt1;
    logic                  w_acc;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [BE_WIDTH-1:0]   w_be;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [c_IDXW-1:0]     w_idx;
    logic [DATA_WIDTH-1:0] w_rword;
    logic                  w_unused_addr;

    // Under contention the port that was not granted last wins.
    assign w_gnt0 = req0_i & (~req1_i | r_last);
    assign w_gnt1 = req1_i & (~req0_i | ~r_last);
    assign w_acc  = w_gnt0 | w_gnt1;

    assign w_we    = w_gnt1 ? we1_i   : we0_i;
    assign w_addr  = w_gnt1 ? addr1_i : addr0_i;
    assign w_be    = w_gnt1 ? be1_i   : be0_i;
    assign w_wdata = w_gnt1 ? data1_i : data0_i;
    assign w_idx   = w_addr[c_OFS +: c_IDXW];

    // Upper bits alias modulo DEPTH and byte-offset bits are don't-care.
    assign w_unused_addr = ^{addr0_i, addr1_i};

    // Response word reflects the array contents after any write this edge.
    always_comb begin
        w_rword = r_mem[w_idx];
        for (int b = 0; b < BE_WIDTH; b++) begin
            if (w_we && w_be[b]) begin
                w_rword[8*b +: 8] = w_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_acc && w_we) begin
            for (int b = 0; b < BE_WIDTH; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_last    <= 1'b1;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_data0   <= '0;
            r_data1   <= '0;
        end else begin
            r_rvalid0 <= w_gnt0;
            r_rvalid1 <= w_gnt1;
            if (w_acc) begin
                r_last <= w_gnt1;
            end
            if (w_gnt0) begin
                r_data0 <= w_rword;
            end
            if (w_gnt1) begin
                r_data1 <= w_rword;
            end
        end
    end

    assign gnt0_o    = w_gnt0;
    assign gnt1_o    = w_gnt1;
    assign rvalid0_o = r_rvalid0;
    assign rvalid1_o = r_rvalid1;
    assign data0_o   = r_data0;
    assign data1_o   = r_data1;

endmodule
`default_nettype wire

// File: tb/tb_peripheral_mpram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_peripheral_mpram_arbiter
// Description : Directed plus randomized bench against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_peripheral_mpram_arbiter;

    localparam int AW    = 32;
    localparam int DW    = 16;
    localparam int BW    = DW / 8;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req  [2];
    logic          we   [2];
    logic [AW-1:0] addr [2];
    logic [BW-1:0] be   [2];
    logic [DW-1:0] wd   [2];
    logic          gnt0, gnt1, rv0, rv1;
    logic [DW-1:0] d0, d1;

    // Reference model state
    logic [DW-1:0] m_mem [DEPTH];
    int            m_last;
    logic          m_rv  [2];
    logic [DW-1:0] m_d   [2];
    int            m_w;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    peripheral_mpram_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) u_dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .req0_i    (req[0]),
        .we0_i     (we[0]),
        .addr0_i   (addr[0]),
        .be0_i     (be[0]),
        .data0_i   (wd[0]),
        .gnt0_o    (gnt0),
        .rvalid0_o (rv0),
        .data0_o   (d0),
        .req1_i    (req[1]),
        .we1_i     (we[1]),
        .addr1_i   (addr[1]),
        .be1_i     (be[1]),
        .data1_i   (wd[1]),
        .gnt1_o    (gnt1),
        .rvalid1_o (rv1),
        .data1_o   (d1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_req(input int p, input logic w, input logic [AW-1:0] a,
                           input logic [BW-1:0] b, input logic [DW-1:0] d);
        req[p] = 1'b1; we[p] = w; addr[p] = a; be[p] = b; wd[p] = d;
    endtask

    task automatic clr_req();
        for (int p = 0; p < 2; p++) begin
            req[p] = 1'b0; we[p] = 1'b0; addr[p] = '0; be[p] = '0; wd[p] = '0;
        end
    endtask

    task automatic model_reset();
        m_last = 1;
        for (int p = 0; p < 2; p++) begin
            m_rv[p] = 1'b0;
            m_d[p]  = '0;
        end
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, "_rv0"}, rv0, m_rv[0]);
        check_eq({tag, "_rv1"}, rv1, m_rv[1]);
        check_eq({tag, "_d0"},  d0,  m_d[0]);
        check_eq({tag, "_d1"},  d1,  m_d[1]);
    endtask

    // Called at a negedge with inputs applied; returns at the next negedge.
    task automatic step(output int g_obs);
        int idx;
        #1;
        if (req[0] && req[1]) m_w = 1 - m_last;
        else if (req[0])      m_w = 0;
        else if (req[1])      m_w = 1;
        else                  m_w = -1;
        check_eq("gnt0", gnt0, m_w == 0);
        check_eq("gnt1", gnt1, m_w == 1);
        g_obs = gnt1 ? 1 : (gnt0 ? 0 : -1);
        @(posedge clk);
        if (m_w >= 0) begin
            idx = int'((addr[m_w] / BW) % DEPTH);
            if (we[m_w]) begin
                for (int b = 0; b < BW; b++)
                    if (be[m_w][b]) m_mem[idx][8*b +: 8] = wd[m_w][8*b +: 8];
            end
            m_d[m_w]      = m_mem[idx];
            m_rv[m_w]     = 1'b1;
            m_rv[1 - m_w] = 1'b0;
            m_last        = m_w;
        end else begin
            m_rv[0] = 1'b0;
            m_rv[1] = 1'b0;
        end
        #1;
        check_outputs("rsp");
        @(negedge clk);
    endtask

    task automatic do_reset(input int ncyc);
        rst_n = 1'b0;
        clr_req();
        model_reset();
        repeat (ncyc) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rst_gnt0", gnt0, 1'b0);
        check_eq("rst_gnt1", gnt1, 1'b0);
        check_outputs("rst");
        @(negedge clk);
    endtask

    logic          pend [2];
    int            g;

    initial begin
        clr_req();
        model_reset();
        rst_n = 1'b0;
        @(negedge clk);
        do_reset(3);

        // Idle: no grants and no responses
        for (int i = 0; i < 10; i++) step(g);

        // Fill the whole array through port 0 so every later read is known
        for (int i = 0; i < DEPTH; i++) begin
            set_req(0, 1'b1, AW'(i * BW), '1, DW'($urandom));
            step(g);
        end
        clr_req();

        // Single write/read on port 1
        set_req(1, 1'b1, 32'h0000_0010, 2'b11, 16'hBEEF);
        step(g);
        check_eq("p1_wr_gnt", g, 1);
        check_eq("p1_wr_data", d1, 16'hBEEF);
        set_req(1, 1'b0, 32'h0000_0010, 2'b00, 16'h0000);
        step(g);
        check_eq("p1_rd_data", d1, 16'hBEEF);
        check_eq("p1_rd_rv", rv1, 1'b1);
        clr_req();
        step(g);
        check_eq("p1_rv_one_cycle", rv1, 1'b0);

        // Byte enables on word 5
        set_req(0, 1'b1, 32'h0000_000A, 2'b11, 16'h1234); step(g);
        set_req(0, 1'b1, 32'h0000_000A, 2'b10, 16'hAB00); step(g);
        check_eq("be_hi_wr", d0, 16'hAB34);
        set_req(0, 1'b0, 32'h0000_000A, 2'b00, 16'h0000); step(g);
        check_eq("be_rd", d0, 16'hAB34);
        set_req(0, 1'b1, 32'h0000_000A, 2'b00, 16'hFFFF); step(g);
        check_eq("be_none_wr", d0, 16'hAB34);
        set_req(0, 1'b0, 32'h0000_000A, 2'b00, 16'h0000); step(g);
        check_eq("be_none_rd", d0, 16'hAB34);
        clr_req();

        // Contention straight from reset alternates 0,1,0,1,...
        do_reset(2);
        for (int i = 0; i < 6; i++) begin
            set_req(0, 1'b0, AW'(2 * i), 2'b00, 16'h0);
            set_req(1, 1'b0, AW'(2 * i + 40), 2'b00, 16'h0);
            step(g);
            check_eq("contend_order", g, i % 2);
        end
        clr_req();

        // Aliasing (0x200 -> word 0) and read-after-write across ports
        set_req(0, 1'b1, 32'h0000_0200, 2'b11, 16'h5A5A); step(g);
        clr_req();
        set_req(1, 1'b0, 32'h0000_0000, 2'b00, 16'h0); step(g);
        check_eq("alias_raw", d1, 16'h5A5A);
        clr_req();

        // Reset mid-operation drops the pending response, keeps the array
        set_req(0, 1'b1, 32'h0000_0006, 2'b11, 16'h7777); step(g);
        check_eq("mid_wr_d0", d0, 16'h7777);
        set_req(0, 1'b0, 32'h0000_0006, 2'b00, 16'h0);
        #1;
        check_eq("mid_rd_gnt", gnt0, 1'b1);
        #1;
        rst_n = 1'b0;
        clr_req();
        model_reset();
        #1;
        check_eq("mid_async_d0", d0, 16'h0);
        check_eq("mid_async_rv0", rv0, 1'b0);
        @(posedge clk);
        #1;
        check_eq("mid_no_rv0", rv0, 1'b0);
        check_eq("mid_d0_zero", d0, 16'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        set_req(0, 1'b0, 32'h0000_0006, 2'b00, 16'h0); step(g);
        check_eq("mid_retained", d0, 16'h7777);
        clr_req();
        step(g);

        // Randomized traffic, each requester holds its request until granted
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        for (int i = 0; i < 600; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p]) begin
                    if ($urandom_range(0, 3) != 0) begin
                        set_req(p, 1'($urandom), AW'($urandom), BW'($urandom), DW'($urandom));
                        pend[p] = 1'b1;
                    end else begin
                        req[p] = 1'b0;
                    end
                end
            end
            step(g);
            if (m_w >= 0) pend[m_w] = 1'b0;
        end
        clr_req();
        step(g);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
